// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - N-channel button synchroniser, integrity-counter debounce, press/release pulses
// Optional auto-repeat of press_pulse while a button is held: define BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce_multi #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 20,
    parameter int STABLE_CNT = 500000,
    parameter int REP_DELAY  = 50000000,
    parameter int REP_RATE   = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    input  logic            clr,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            any_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int REP_W = (REP_DELAY < 2) ? 1 : $clog2(REP_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REP_DELAY - REP_RATE);
`endif

    if (N_CH < 1 || STABLE_CNT < 1 || STABLE_CNT >= (2 ** CNT_W) ||
        REP_RATE < 1 || REP_RATE > REP_DELAY) begin : g_param_check
        $error("btn_debounce_multi: invalid parameter set");
    end

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             level_r;
        logic             press_r;
        logic             rel_r;
        logic             accept;
        logic             rep_fire;

        // New level is taken on the STABLE_CNT-th consecutive disagreeing cycle.
        assign accept = (sync2[i] != level_r) && (cnt == CNT_LAST);

`ifdef BTN_DEBOUNCE_REPEAT_EN
        logic [REP_W-1:0] rcnt;

        // A release being accepted this cycle wins over a repeat that would coincide.
        assign rep_fire = level_r && !accept && (rcnt == REP_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rcnt <= '0;
            end else if (clr || !level_r || accept) begin
                rcnt <= '0;
            end else if (rcnt == REP_LAST) begin
                rcnt <= REP_RELOAD;
            end else begin
                rcnt <= rcnt + REP_W'(1);
            end
        end
`else
        assign rep_fire = 1'b0;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt     <= '0;
                level_r <= 1'b0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
            end else if (clr) begin
                cnt     <= '0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
            end else begin
                press_r <= (accept && sync2[i]) || rep_fire;
                rel_r   <= accept && !sync2[i];
                if (sync2[i] == level_r || accept) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (accept) begin
                    level_r <= sync2[i];
                end
            end
        end

        assign btn_level[i]     = level_r;
        assign press_pulse[i]   = press_r;
        assign release_pulse[i] = rel_r;
    end

    assign any_press = |press_pulse;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - scoreboard bench for btn_debounce_multi (STABLE_CNT=4 and STABLE_CNT=1 instances)
module tb_btn_debounce_multi;

    localparam int REP_DELAY = 10;
    localparam int REP_RATE  = 3;
    localparam int LAT       = 6;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       clr_b = 1'b0;
    logic [1:0] btn_a = 2'b00;
    logic [1:0] btn_b = 2'b00;
    logic [1:0] level_a, press_a, rel_a;
    logic [1:0] level_b, press_b, rel_b;
    logic       any_a, any_b;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    ev_t qa[$];
    ev_t qb[$];
    ev_t mev;
    logic [1:0] ep, er;

    btn_debounce_multi #(.N_CH(2), .CNT_W(4), .STABLE_CNT(4), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_a), .clr(clr),
        .btn_level(level_a), .press_pulse(press_a), .release_pulse(rel_a), .any_press(any_a)
    );

    btn_debounce_multi #(.N_CH(2), .CNT_W(4), .STABLE_CNT(1), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_b), .clr(clr_b),
        .btn_level(level_b), .press_pulse(press_b), .release_pulse(rel_b), .any_press(any_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard: every cycle the pulse outputs must equal the entry due now, or zero.
    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].cyc < cyc) begin
            mev = qa.pop_front();
            n_cmp++; n_fail++;
            $display("FAIL sb_a_missed: event for cycle %0d not seen, now cycle %0d", mev.cyc, cyc);
        end
        ep = 2'b00; er = 2'b00;
        if (qa.size() > 0 && qa[0].cyc == cyc) begin
            mev = qa.pop_front(); ep = mev.press; er = mev.rel;
        end
        n_cmp++;
        if ({press_a, rel_a} !== {ep, er}) begin
            n_fail++;
            $display("FAIL sb_a_pulses cyc %0d: got press=%b rel=%b expected press=%b rel=%b", cyc, press_a, rel_a, ep, er);
        end
        n_cmp++;
        if (any_a !== (|ep)) begin
            n_fail++;
            $display("FAIL sb_a_any_press cyc %0d: got %b expected %b", cyc, any_a, |ep);
        end
        while (qb.size() > 0 && qb[0].cyc < cyc) begin
            mev = qb.pop_front();
            n_cmp++; n_fail++;
            $display("FAIL sb_b_missed: event for cycle %0d not seen, now cycle %0d", mev.cyc, cyc);
        end
        ep = 2'b00; er = 2'b00;
        if (qb.size() > 0 && qb[0].cyc == cyc) begin
            mev = qb.pop_front(); ep = mev.press; er = mev.rel;
        end
        n_cmp++;
        if ({press_b, rel_b, any_b} !== {ep, er, |ep}) begin
            n_fail++;
            $display("FAIL sb_b_pulses cyc %0d: got press=%b rel=%b any=%b expected press=%b rel=%b any=%b",
                     cyc, press_b, rel_b, any_b, ep, er, |ep);
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected pulses for a press driven at p and released at r on DUT A.
    task automatic push_hold(input logic [1:0] m, input int p, input int r);
        int acc;
        int drop;
        acc  = p + LAT;
        drop = r + LAT;
        qa.push_back(ev_t'{acc, m, 2'b00});
`ifdef BTN_DEBOUNCE_REPEAT_EN
        for (int t = acc + REP_DELAY; t < drop; t += REP_RATE) qa.push_back(ev_t'{t, m, 2'b00});
`endif
        qa.push_back(ev_t'{drop, 2'b00, m});
    endtask

    task automatic test_reset;
        btn_a = 2'b11;
        wait_n(4);
        n_cmp++;
        if ({level_a, press_a, rel_a} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 000000", {level_a, press_a, rel_a});
        end
        btn_a = 2'b00;
        wait_n(3);
        rst = 1'b0;
        wait_n(8);
        n_cmp++;
        if (level_a !== 2'b00 || level_b !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle_level: got a=%b b=%b expected 00", level_a, level_b);
        end
    endtask

    task automatic test_clean_press;
        int p;
        p = cyc;
        btn_a = 2'b01;
        push_hold(2'b01, p, p + 20);
        wait_n(5);
        n_cmp++;
        if (level_a !== 2'b00) begin
            n_fail++; $display("FAIL clean_level_early: got %b expected 00", level_a);
        end
        wait_n(1);
        n_cmp++;
        if (level_a !== 2'b01) begin
            n_fail++; $display("FAIL clean_level_accept: got %b expected 01", level_a);
        end
        wait_n(14);
        btn_a = 2'b00;
        wait_n(6);
        n_cmp++;
        if (level_a !== 2'b00) begin
            n_fail++; $display("FAIL clean_level_release: got %b expected 00", level_a);
        end
        wait_n(4);
    endtask

    task automatic test_bounce;
        int f;
        for (int k = 0; k < 4; k++) begin
            btn_a = (k % 2 == 0) ? 2'b01 : 2'b00;
            wait_n(2);
        end
        f = cyc;
        btn_a = 2'b01;
        push_hold(2'b01, f, f + 10);
        wait_n(5);
        n_cmp++;
        if (level_a !== 2'b00) begin
            n_fail++; $display("FAIL bounce_level_early: got %b expected 00", level_a);
        end
        wait_n(5);
        btn_a = 2'b00;
        wait_n(12);
    endtask

    task automatic test_simultaneous;
        int s;
        s = cyc;
        btn_a = 2'b11;
        push_hold(2'b11, s, s + 15);
        wait_n(6);
        n_cmp++;
        if ({press_a, any_a} !== 3'b111) begin
            n_fail++; $display("FAIL simul_press: got press=%b any=%b expected 11 1", press_a, any_a);
        end
        wait_n(9);
        btn_a = 2'b00;
        wait_n(6);
        n_cmp++;
        if ({rel_a, press_a} !== 4'b1100) begin
            n_fail++; $display("FAIL simul_release: got rel=%b press=%b expected 11 00", rel_a, press_a);
        end
        wait_n(4);
    endtask

    task automatic test_clr;
        int c;
        int r;
        c = cyc;
        btn_a = 2'b01;
        qa.push_back(ev_t'{c + 9, 2'b01, 2'b00});
        wait_n(4);
        clr = 1'b1;
        wait_n(1);
        clr = 1'b0;
        wait_n(3);
        n_cmp++;
        if (level_a !== 2'b00) begin
            n_fail++; $display("FAIL clr_press_deferred: got %b expected 00", level_a);
        end
        wait_n(1);
        n_cmp++;
        if (level_a !== 2'b01) begin
            n_fail++; $display("FAIL clr_press_accept: got %b expected 01", level_a);
        end
        wait_n(2);
        r = cyc;
        btn_a = 2'b00;
        qa.push_back(ev_t'{r + 10, 2'b00, 2'b01});
        wait_n(5);
        clr = 1'b1;
        wait_n(1);
        clr = 1'b0;
        wait_n(3);
        n_cmp++;
        if (level_a !== 2'b01) begin
            n_fail++; $display("FAIL clr_release_deferred: got %b expected 01", level_a);
        end
        wait_n(1);
        n_cmp++;
        if (level_a !== 2'b00) begin
            n_fail++; $display("FAIL clr_release_accept: got %b expected 00", level_a);
        end
        wait_n(4);
    endtask

    task automatic test_rst_midcount;
        int k;
        int d;
        k = cyc;
        btn_a = 2'b10;
        qa.push_back(ev_t'{k + LAT, 2'b10, 2'b00});
        wait_n(8);
        n_cmp++;
        if (level_a !== 2'b10) begin
            n_fail++; $display("FAIL rst_pre_level: got %b expected 10", level_a);
        end
        btn_a = 2'b11;
        wait_n(3);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({level_a, press_a, rel_a} !== 6'b0) begin
            n_fail++; $display("FAIL rst_async_clear: got %b expected 000000", {level_a, press_a, rel_a});
        end
        wait_n(3);
        d = cyc;
        rst = 1'b0;
        push_hold(2'b11, d, d + 10);
        wait_n(5);
        n_cmp++;
        if (level_a !== 2'b00) begin
            n_fail++; $display("FAIL rst_no_early_press: got %b expected 00", level_a);
        end
        wait_n(1);
        n_cmp++;
        if (level_a !== 2'b11) begin
            n_fail++; $display("FAIL rst_held_press: got %b expected 11", level_a);
        end
        wait_n(4);
        btn_a = 2'b00;
        wait_n(10);
    endtask

    task automatic test_stable1;
        int g;
        g = cyc;
        btn_b = 2'b10;
        qb.push_back(ev_t'{g + 3, 2'b10, 2'b00});
        qb.push_back(ev_t'{g + 4, 2'b00, 2'b10});
        wait_n(1);
        btn_b = 2'b00;
        wait_n(2);
        n_cmp++;
        if ({level_b, press_b} !== 4'b1010) begin
            n_fail++; $display("FAIL stable1_press: got level=%b press=%b expected 10 10", level_b, press_b);
        end
        wait_n(1);
        n_cmp++;
        if ({level_b, rel_b} !== 4'b0010) begin
            n_fail++; $display("FAIL stable1_release: got level=%b rel=%b expected 00 10", level_b, rel_b);
        end
        wait_n(3);
    endtask

    task automatic test_repeat;
        int p;
        int seen;
        int want;
        p = cyc;
        seen = 0;
        btn_a = 2'b01;
        push_hold(2'b01, p, p + 26);
        for (int k = 0; k < 40; k++) begin
            wait_n(1);
            if (cyc == p + 26) btn_a = 2'b00;
            if (press_a[0] === 1'b1) seen++;
        end
`ifdef BTN_DEBOUNCE_REPEAT_EN
        want = 7;
`else
        want = 1;
`endif
        n_cmp++;
        if (seen !== want) begin
            n_fail++; $display("FAIL repeat_count: got %0d press pulses expected %0d", seen, want);
        end
        wait_n(4);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_clr();
        test_rst_midcount();
        test_stable1();
        test_repeat();
        wait_n(5);
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d/%0d pending events expected 0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000ns expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
